// File: rtl/uart_boot_loader.sv
// uart_boot_loader: detects a UART key, holds the core in reset, loads imem words, then releases the core
module uart_boot_loader #(
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned TIMEOUT_MS   = 2000,
  parameter int unsigned KEY_LEN      = 2,
  parameter logic [31:0] KEY          = 32'h0000702d,
  parameter logic [7:0]  PAD_BYTE     = 8'h5f,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned LOAD_BASE    = 0,
  parameter int unsigned RST_HOLD     = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              uart_rx_irq,
  input  logic [7:0]        uart_rx_byte,
  input  logic              mem_ready_i,
  output logic              reset_o,
  output logic [31:0]       reset_cause_reg,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [2:0]        state_o
);
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_KEY = 3'd1, S_LEN = 3'd2, S_DATA = 3'd3, S_HOLD = 3'd4} state_t;
  localparam logic [31:0] TMO_LIM   = 32'(SYS_CLK_FREQ / 1000 * TIMEOUT_MS);
  localparam logic [1:0]  LAST_IDX  = 2'(KEY_LEN - 1);
  localparam logic [32:0] LEN_MAX   = 33'd4 << ADDR_W;
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
  state_t      state;
  logic [1:0]  idx, lcnt, lane;
  logic [31:0] len, cnt, acc_d, tmo, hcnt, word, len_n;
  logic [3:0]  acc_s, strb;
  logic        last, fin, tmo_hit, pend;
  assign state_o = state;
  // Next word image, length shift-in and session event decodes
  always_comb begin
    lane    = cnt[1:0];
    word    = acc_d | (32'(uart_rx_byte) << {lane, 3'b000});
    strb    = acc_s | (4'b1 << lane);
    len_n   = {uart_rx_byte, len[31:8]};
    fin     = cnt + 32'd1 == len;
    tmo_hit = !uart_rx_irq && tmo >= TMO_LIM - 32'd1;
    pend    = mem_we_o && !mem_ready_i;
  end
  // Inter-byte timer: cleared by every byte, runs only inside a session
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) tmo <= '0;
    else tmo <= (uart_rx_irq || state == S_IDLE || state == S_HOLD) ? '0 : tmo + 32'd1;
  // Session FSM with registered core reset, cause and memory write port
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= S_IDLE;
      idx <= '0;
      lcnt <= '0;
      len <= '0;
      cnt <= '0;
      acc_d <= '0;
      acc_s <= '0;
      last <= 1'b0;
      hcnt <= '0;
      reset_o <= 1'b1;
      reset_cause_reg <= '0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      busy_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (uart_rx_irq && uart_rx_byte == KEY[7:0]) begin
            idx <= 2'd1;
            busy_o <= 1'b1;
            if (KEY_LEN == 1) begin
              state <= S_LEN;
              lcnt <= '0;
              reset_o <= 1'b0;
              reset_cause_reg <= 32'h1;
              err_o <= 1'b0;
            end else state <= S_KEY;
          end
        S_KEY:
          if (uart_rx_irq) begin
            if (uart_rx_byte == KEY[{idx, 3'b000} +: 8]) begin
              if (idx == LAST_IDX) begin
                state <= S_LEN;
                lcnt <= '0;
                reset_o <= 1'b0;
                reset_cause_reg <= 32'h1;
                err_o <= 1'b0;
              end else idx <= idx + 2'd1;
            end else if (uart_rx_byte != PAD_BYTE) begin
              state <= S_IDLE;
              busy_o <= 1'b0;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
            busy_o <= 1'b0;
          end
        S_LEN:
          if (uart_rx_irq) begin
            len <= len_n;
            lcnt <= lcnt + 2'd1;
            if (lcnt == 2'd3) begin
              cnt <= '0;
              acc_d <= '0;
              acc_s <= '0;
              last <= 1'b0;
              hcnt <= '0;
              if (len_n == '0) begin
                state <= S_HOLD;
                reset_cause_reg <= reset_cause_reg | 32'h2;
              end else if ({1'b0, len_n} > LEN_MAX) begin
                state <= S_HOLD;
                reset_cause_reg <= reset_cause_reg | 32'h10;
                err_o <= 1'b1;
              end else state <= S_DATA;
            end
          end else if (tmo_hit) begin
            state <= S_HOLD;
            hcnt <= '0;
            reset_cause_reg <= reset_cause_reg | 32'h4;
            err_o <= 1'b1;
          end
        S_DATA: begin
          if (mem_we_o && mem_ready_i) begin
            mem_we_o <= 1'b0;
            if (last) begin
              state <= S_HOLD;
              hcnt <= '0;
              reset_cause_reg <= reset_cause_reg | 32'h2;
            end
          end else if (tmo_hit) begin
            state <= S_HOLD;
            hcnt <= '0;
            mem_we_o <= 1'b0;
            reset_cause_reg <= reset_cause_reg | 32'h4;
            err_o <= 1'b1;
          end
          if (uart_rx_irq && cnt != len) begin
            cnt <= cnt + 32'd1;
            if (lane == 2'd3 || fin) begin
              if (pend) begin
                state <= S_HOLD;
                hcnt <= '0;
                mem_we_o <= 1'b0;
                reset_cause_reg <= reset_cause_reg | 32'h8;
                err_o <= 1'b1;
              end else begin
                mem_we_o <= 1'b1;
                mem_addr_o <= ADDR_W'(LOAD_BASE) + cnt[ADDR_W+1:2];
                mem_wdata_o <= word;
                mem_wstrb_o <= strb;
                acc_d <= '0;
                acc_s <= '0;
                last <= fin;
              end
            end else begin
              acc_d <= word;
              acc_s <= strb;
            end
          end
        end
        S_HOLD:
          if (hcnt == HOLD_LAST) begin
            state <= S_IDLE;
            reset_o <= 1'b1;
            busy_o <= 1'b0;
          end else hcnt <= hcnt + 32'd1;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scenario tasks with a write scoreboard for uart_boot_loader
module tb_uart_boot_loader;
  typedef struct packed {logic [11:0] a; logic [31:0] d; logic [3:0] s;} wr_t;
  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        uart_rx_irq = 1'b0;
  logic [7:0]  uart_rx_byte = 8'h00;
  logic        mem_ready_i = 1'b1;
  logic        reset_o, mem_we_o, busy_o, err_o;
  logic [31:0] reset_cause_reg, mem_wdata_o;
  logic [11:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [2:0]  state_o;
  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];
  uart_boot_loader #(.SYS_CLK_FREQ(1000000), .TIMEOUT_MS(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .uart_rx_irq(uart_rx_irq), .uart_rx_byte(uart_rx_byte),
    .mem_ready_i(mem_ready_i), .reset_o(reset_o), .reset_cause_reg(reset_cause_reg),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
  );
  always #5 clk = ~clk;
  // A write is accepted at the next posedge when we and ready are both high here
  always @(negedge clk)
    if (reset_i && mem_we_o && mem_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected got addr=%0h data=%h strb=%h", mem_addr_o, mem_wdata_o, mem_wstrb_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== e) begin
          failures++;
          $display("FAIL write got addr=%0h data=%h strb=%h exp addr=%0h data=%h strb=%h",
                   mem_addr_o, mem_wdata_o, mem_wstrb_o, e.a, e.d, e.s);
        end
      end
    end
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    uart_rx_irq = 1'b1;
    uart_rx_byte = b;
    @(posedge clk); #1;
    uart_rx_irq = 1'b0;
  endtask
  task automatic send_key();
    send_byte(8'h2d);
    send_byte(8'h70);
  endtask
  task automatic send_len(input logic [31:0] l);
    for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (state_o != 3'd0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes_missing got pending=%0d exp 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({reset_o, reset_cause_reg, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, busy_o, err_o, state_o} !==
        {1'b1, 32'h0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_values got rst=%b cause=%h we=%b busy=%b state=%0d", reset_o, reset_cause_reg, mem_we_o, busy_o, state_o);
    end
    reset_i = 1'b1;
  endtask
  task automatic test_bad_key();
    send_byte(8'h2d);
    checks++;
    if (state_o !== 3'd1) begin failures++; $display("FAIL badkey_state_key got %0d exp 1", state_o); end
    send_byte(8'h78);
    checks++;
    if ({state_o, reset_o, reset_cause_reg, busy_o} !== {3'd0, 1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL badkey_idle got state=%0d rst=%b cause=%h busy=%b", state_o, reset_o, reset_cause_reg, busy_o);
    end
  endtask
  task automatic test_load();
    int n;
    mem_ready_i = 1'b1;
    send_byte(8'h2d);
    send_byte(8'h5f);
    send_byte(8'h5f);
    checks++;
    if ({state_o, reset_o} !== {3'd1, 1'b1}) begin failures++; $display("FAIL load_pad got state=%0d rst=%b exp 1 1", state_o, reset_o); end
    send_byte(8'h70);
    checks++;
    if ({state_o, reset_o, reset_cause_reg} !== {3'd2, 1'b0, 32'h1}) begin
      failures++;
      $display("FAIL load_accept got state=%0d rst=%b cause=%h exp 2 0 1", state_o, reset_o, reset_cause_reg);
    end
    send_len(32'd5);
    exp_q.push_back('{12'd0, 32'h14131211, 4'hf});
    exp_q.push_back('{12'd1, 32'h00000015, 4'h1});
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
    @(posedge clk); #1;
    checks++;
    if ({state_o, reset_o, reset_cause_reg, err_o} !== {3'd4, 1'b0, 32'h3, 1'b0}) begin
      failures++;
      $display("FAIL load_done got state=%0d rst=%b cause=%h err=%b exp 4 0 3 0", state_o, reset_o, reset_cause_reg, err_o);
    end
    wait_idle(n);
    checks++;
    if (n != 16 || reset_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL load_hold got cycles=%0d rst=%b busy=%b exp 16 1 0", n, reset_o, busy_o);
    end
    check_drained("load");
  endtask
  task automatic test_timeout();
    int n;
    send_key();
    send_len(32'd8);
    for (int i = 0; i < 3; i++) send_byte(8'ha0 + 8'(i));
    repeat (999) @(posedge clk);
    #1;
    checks++;
    if (state_o !== 3'd3) begin failures++; $display("FAIL timeout_early got state=%0d exp 3", state_o); end
    @(posedge clk); #1;
    checks++;
    if ({state_o, reset_cause_reg, err_o, mem_we_o} !== {3'd4, 32'h5, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL timeout_abort got state=%0d cause=%h err=%b we=%b exp 4 5 1 0", state_o, reset_cause_reg, err_o, mem_we_o);
    end
    wait_idle(n);
    checks++;
    if ({state_o, reset_o, reset_cause_reg} !== {3'd0, 1'b1, 32'h5}) begin
      failures++;
      $display("FAIL timeout_release got state=%0d rst=%b cause=%h exp 0 1 5", state_o, reset_o, reset_cause_reg);
    end
  endtask
  task automatic test_overrun();
    int n;
    mem_ready_i = 1'b0;
    send_key();
    send_len(32'd8);
    for (int i = 0; i < 7; i++) send_byte(8'h01 + 8'(i));
    checks++;
    if ({state_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {3'd3, 1'b1, 12'd0, 32'h04030201, 4'hf}) begin
      failures++;
      $display("FAIL overrun_pending got state=%0d we=%b addr=%0h data=%h strb=%h", state_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    send_byte(8'h08);
    checks++;
    if ({state_o, reset_cause_reg, err_o, mem_we_o} !== {3'd4, 32'h9, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL overrun_abort got state=%0d cause=%h err=%b we=%b exp 4 9 1 0", state_o, reset_cause_reg, err_o, mem_we_o);
    end
    wait_idle(n);
    mem_ready_i = 1'b1;
    checks++;
    if (state_o !== 3'd0) begin failures++; $display("FAIL overrun_release got state=%0d exp 0", state_o); end
  endtask
  task automatic test_len_error();
    int n;
    send_key();
    send_len(32'h00004001);
    checks++;
    if ({state_o, reset_cause_reg, err_o, mem_we_o} !== {3'd4, 32'h11, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL lenerr got state=%0d cause=%h err=%b we=%b exp 4 11 1 0", state_o, reset_cause_reg, err_o, mem_we_o);
    end
    wait_idle(n);
    checks++;
    if (state_o !== 3'd0) begin failures++; $display("FAIL lenerr_release got state=%0d exp 0", state_o); end
  endtask
  task automatic test_reset_mid();
    int n;
    mem_ready_i = 1'b0;
    send_key();
    send_len(32'd8);
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
    checks++;
    if ({state_o, mem_we_o} !== {3'd3, 1'b1}) begin failures++; $display("FAIL midrst_pre got state=%0d we=%b exp 3 1", state_o, mem_we_o); end
    reset_i = 1'b0;
    #1;
    checks++;
    if ({reset_o, reset_cause_reg, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, busy_o, err_o, state_o} !==
        {1'b1, 32'h0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL midrst_values got rst=%b cause=%h we=%b busy=%b state=%0d", reset_o, reset_cause_reg, mem_we_o, busy_o, state_o);
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
    mem_ready_i = 1'b1;
    send_key();
    send_len(32'd4);
    exp_q.push_back('{12'd0, 32'ha4a3a2a1, 4'hf});
    for (int i = 0; i < 4; i++) send_byte(8'ha1 + 8'(i));
    @(posedge clk); #1;
    checks++;
    if ({state_o, reset_cause_reg} !== {3'd4, 32'h3}) begin
      failures++;
      $display("FAIL midrst_fresh got state=%0d cause=%h exp 4 3", state_o, reset_cause_reg);
    end
    wait_idle(n);
    checks++;
    if ({state_o, reset_o} !== {3'd0, 1'b1}) begin failures++; $display("FAIL midrst_release got state=%0d rst=%b exp 0 1", state_o, reset_o); end
    check_drained("midrst");
  endtask
  initial begin
    test_reset();
    test_bad_key();
    test_load();
    test_timeout();
    test_overrun();
    test_len_error();
    test_reset_mid();
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
